// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with wrap/saturate modes, constant or external load,
// and a registered terminal-count flag raised on the cycle after a boundary event.
module param_updown_counter #(
  parameter int              WIDTH      = 4,
  parameter longint unsigned LOAD_CONST = 64'd6,
  parameter longint unsigned MAX_COUNT  = (64'd1 << WIDTH) - 64'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             load_sel,
  input  logic [WIDTH-1:0] load_data,
  input  logic             up_down,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] counter,
  output logic             tc
);

  // Reject configurations whose count range cannot be represented.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("param_updown_counter: WIDTH must be in 2..32");
  end
  if (MAX_COUNT < 64'd1 || MAX_COUNT > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("param_updown_counter: MAX_COUNT must be in 1..2**WIDTH-1");
  end
  if (LOAD_CONST > MAX_COUNT) begin : g_bad_load
    $error("param_updown_counter: LOAD_CONST must not exceed MAX_COUNT");
  end

  localparam logic [WIDTH-1:0] MAX_C  = MAX_COUNT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] LOAD_C = LOAD_CONST[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] counter_r;
  logic             tc_r;
  logic [WIDTH-1:0] next_cnt_s;
  logic             next_tc_s;

  // Next-state selection: load beats count; boundaries are compared explicitly
  // so a non-power-of-two MAX_COUNT never relies on natural overflow.
  always_comb begin
    next_cnt_s = counter_r;
    next_tc_s  = 1'b0;
    if (load) begin
      if (load_sel) begin
        if (load_data > MAX_C) begin
          next_cnt_s = MAX_C;
        end else begin
          next_cnt_s = load_data;
        end
      end else begin
        next_cnt_s = LOAD_C;
      end
    end else if (en) begin
      if (up_down) begin
        if (counter_r == MAX_C) begin
          next_tc_s  = 1'b1;
          next_cnt_s = sat_mode ? MAX_C : ZERO_C;
        end else begin
          next_cnt_s = counter_r + ONE_C;
        end
      end else begin
        if (counter_r == ZERO_C) begin
          next_tc_s  = 1'b1;
          next_cnt_s = sat_mode ? ZERO_C : MAX_C;
        end else begin
          next_cnt_s = counter_r - ONE_C;
        end
      end
    end else begin
      next_cnt_s = counter_r;
      next_tc_s  = 1'b0;
    end
  end

  // State register with synchronous reset overriding load and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_r <= ZERO_C;
      tc_r      <= 1'b0;
    end else begin
      counter_r <= next_cnt_s;
      tc_r      <= next_tc_s;
    end
  end

  assign counter = counter_r;
  assign tc      = tc_r;

endmodule
